osc_frame_collector: RTL and testbench



---
 rtl/osc_frame_collector.sv | 107 ++++++++++
 tb/tb_osc_frame_collector.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_frame_collector.sv
// Serial frame collector: hunts a sync pattern in the oscillator bit stream, then
// deserializes WIDTH bits MSB-first into a single-entry valid/ready holding register.
module osc_frame_collector #(
  parameter int                  WIDTH    = 8,
  parameter int                  SYNC_LEN = 4,
  parameter logic [SYNC_LEN-1:0] SYNC     = 4'b1011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             in_frame,
  output logic             overflow,
  output logic [7:0]       sync_cnt
);

  localparam int HW = $clog2(SYNC_LEN + 1);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_t;

  state_t                state_q;
  logic [SYNC_LEN-1:0]   sync_sr_q;
  logic [HW-1:0]         hunt_cnt_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [WIDTH-1:0]      word_sr_q;
  logic                  out_valid_q;
  logic [WIDTH-1:0]      out_data_q;
  logic                  overflow_q;
  logic [7:0]            sync_cnt_q;

  logic [SYNC_LEN-1:0]   sync_win_d;
  logic [WIDTH-1:0]      word_d;
  logic                  match;
  logic                  word_done;
  logic                  xfer;
  logic                  load;

  // The window includes the incoming bit so the completing bit switches state this cycle.
  always_comb begin
    sync_win_d = {sync_sr_q[SYNC_LEN-2:0], din};
    word_d     = {word_sr_q[WIDTH-2:0], din};
    match      = (state_q == HUNT) && din_en && (sync_win_d == SYNC) &&
                 (hunt_cnt_q >= HW'(SYNC_LEN - 1));
    word_done  = (state_q == COLLECT) && din_en && (bit_cnt_q == BW'(WIDTH - 1));
    xfer       = out_valid_q && out_ready;
    load       = !out_valid_q || out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      sync_sr_q   <= '0;
      hunt_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      word_sr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      sync_cnt_q  <= '0;
    end else begin
      if (xfer) out_valid_q <= 1'b0;
      case (state_q)
        HUNT: begin
          if (din_en) begin
            sync_sr_q <= sync_win_d;
            if (hunt_cnt_q != HW'(SYNC_LEN)) hunt_cnt_q <= hunt_cnt_q + 1'b1;
            if (match) begin
              state_q   <= COLLECT;
              bit_cnt_q <= '0;
              if (sync_cnt_q != 8'hFF) sync_cnt_q <= sync_cnt_q + 8'd1;
            end
          end
        end
        COLLECT: begin
          if (din_en) begin
            word_sr_q <= word_d;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (word_done) begin
              // A full holding register that is not draining this edge loses the new word.
              if (load) begin
                out_data_q  <= word_d;
                out_valid_q <= 1'b1;
              end else begin
                overflow_q <= 1'b1;
              end
              state_q    <= HUNT;
              sync_sr_q  <= '0;
              hunt_cnt_q <= '0;
            end
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign in_frame  = (state_q == COLLECT);
  assign overflow  = overflow_q;
  assign sync_cnt  = sync_cnt_q;

endmodule

// File: tb/tb_osc_frame_collector.sv
// Bench for osc_frame_collector: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a bit-queue reference model.
module tb_osc_frame_collector;

  localparam int                WIDTH    = 8;
  localparam int                SYNC_LEN = 4;
  localparam logic [SYNC_LEN-1:0] SYNC   = 4'b1011;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             din;
  logic             din_en;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             in_frame;
  logic             overflow;
  logic [7:0]       sync_cnt;

  always #5 clk = ~clk;

  osc_frame_collector #(.WIDTH(WIDTH), .SYNC_LEN(SYNC_LEN), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .in_frame(in_frame),
    .overflow(overflow), .sync_cnt(sync_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Hunt keeps the bits received since the last frame; collect keeps data bits.
  bit               hunt_q[$];
  bit               data_q[$];
  bit               m_coll  = 1'b0;
  bit               m_valid = 1'b0;
  logic [WIDTH-1:0] m_data  = '0;
  bit               m_ovf   = 1'b0;
  int               m_sync  = 0;

  task automatic model_reset();
    hunt_q.delete();
    data_q.delete();
    m_coll  = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_ovf   = 1'b0;
    m_sync  = 0;
  endtask

  task automatic model_step(input bit d, input bit en, input bit rdy);
    bit xfer;
    bit loaded;
    int v;
    xfer   = m_valid && rdy;
    loaded = 1'b0;
    if (en) begin
      if (!m_coll) begin
        hunt_q.push_back(d);
        if (hunt_q.size() > SYNC_LEN) void'(hunt_q.pop_front());
        v = 0;
        foreach (hunt_q[i]) v = v * 2 + int'(hunt_q[i]);
        if (hunt_q.size() == SYNC_LEN && v == int'(SYNC)) begin
          m_coll = 1'b1;
          data_q.delete();
          if (m_sync < 255) m_sync++;
        end
      end else begin
        data_q.push_back(d);
        if (data_q.size() == WIDTH) begin
          v = 0;
          foreach (data_q[i]) v = v * 2 + int'(data_q[i]);
          if (!m_valid || rdy) begin
            m_data = WIDTH'(v);
            loaded = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
          m_coll = 1'b0;
          hunt_q.delete();
          data_q.delete();
        end
      end
    end
    if (loaded) m_valid = 1'b1;
    else if (xfer) m_valid = 1'b0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("in_frame",  32'(in_frame),  32'(m_coll));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("sync_cnt",  32'(sync_cnt),  32'(m_sync));
  end

  // ---------------- driver tasks ----------------
  int               obs_inframe;
  int               obs_valid;
  logic [WIDTH-1:0] obs_data;

  task automatic obs_clear();
    obs_inframe = 0;
    obs_valid   = 0;
    obs_data    = '0;
  endtask

  // One clock: drive at the negedge, step the model at the posedge, return at the next negedge.
  task automatic tick(input bit d, input bit en, input bit rdy);
    din       = d;
    din_en    = en;
    out_ready = rdy;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(d, en, rdy);
    @(negedge clk);
    if (in_frame) obs_inframe++;
    if (out_valid) begin
      obs_valid++;
      obs_data = out_data;
    end
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input bit rdy);
    for (int i = n - 1; i >= 0; i--) tick(bits[i], 1'b1, rdy);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_valid",    32'(out_valid), 32'd0);
    chk("rst_data",     32'(out_data),  32'd0);
    chk("rst_in_frame", 32'(in_frame),  32'd0);
    chk("rst_overflow", 32'(overflow),  32'd0);
    chk("rst_sync_cnt", 32'(sync_cnt),  32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    obs_clear();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int i;
    rst = 1'b1;
    din = 1'b0;
    din_en = 1'b0;
    out_ready = 1'b0;
    obs_clear();
    @(negedge clk);
    rst = 1'b0;

    // Reset and idle
    do_reset();
    repeat (50) tick(1'b0, 1'b1, 1'b1);
    chk("idle_in_frame", 32'(obs_inframe), 32'd0);
    chk("idle_sync_cnt", 32'(sync_cnt), 32'd0);

    // Basic frame
    do_reset();
    send_bits(32'b1011_10100101, 12, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    chk("basic_valid_cycles", 32'(obs_valid), 32'd1);
    chk("basic_data", 32'(obs_data), 32'hA5);
    chk("basic_sync_cnt", 32'(sync_cnt), 32'd1);
    chk("basic_in_frame_cycles", 32'(obs_inframe), 32'd8);

    // Overlapping hunt with strobe gaps every third cycle
    do_reset();
    k = 0;
    i = 13;
    while (i >= 0) begin
      if (k % 3 == 2) tick(1'($urandom_range(0, 1)), 1'b0, 1'b1);
      else begin
        tick(((32'b101011_11110000 >> i) & 32'd1) != 0, 1'b1, 1'b1);
        i--;
      end
      k++;
    end
    tick(1'b0, 1'b0, 1'b1);
    chk("gap_data", 32'(obs_data), 32'hF0);
    chk("gap_valid_cycles", 32'(obs_valid), 32'd1);
    chk("gap_sync_cnt", 32'(sync_cnt), 32'd1);

    // Backpressure / overflow
    do_reset();
    send_bits(32'b1011_00111100, 12, 1'b0);
    send_bits(32'b1011_10000001, 12, 1'b0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data", 32'(out_data), 32'h3C);
    chk("bp_overflow", 32'(overflow), 32'd1);
    chk("bp_sync_cnt", 32'(sync_cnt), 32'd2);
    tick(1'b0, 1'b0, 1'b1);
    chk("bp_drain_valid", 32'(out_valid), 32'd0);
    chk("bp_overflow_sticky", 32'(overflow), 32'd1);

    // Simultaneous drain and complete
    do_reset();
    send_bits(32'b1011_00010001, 12, 1'b0);
    chk("dc_first", 32'(out_data), 32'h11);
    send_bits(32'b1011_0010001, 11, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    chk("dc_valid", 32'(out_valid), 32'd1);
    chk("dc_data", 32'(out_data), 32'h22);
    chk("dc_overflow", 32'(overflow), 32'd0);

    // Reset mid-frame, then a clean frame
    do_reset();
    send_bits(32'b1011_1010, 8, 1'b1);
    do_reset();
    chk("mid_rst_valid", 32'(obs_valid), 32'd0);
    send_bits(32'b1011_01011010, 12, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    chk("post_rst_data", 32'(obs_data), 32'h5A);
    chk("post_rst_valid_cycles", 32'(obs_valid), 32'd1);

    // Saturation of the sync counter
    do_reset();
    repeat (300) send_bits({20'd0, 4'b1011, 8'($urandom)}, 12, 1'b1);
    chk("sat_sync_cnt", 32'(sync_cnt), 32'd255);

    // Randomized traffic, checked by the model every cycle
    do_reset();
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0)
        send_bits({28'd0, SYNC}, SYNC_LEN, 1'($urandom_range(0, 1)));
      else
        tick(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
